// File: rtl/ccff_chain_loader_if.sv
// Bitstream word stream between the fabric distributor (master) and a CCFF
// chain loader (slave).
interface ccff_chain_loader_if #(
    parameter int WORD_W = 8
);
    logic [WORD_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/ccff_chain_loader.sv
// Serialises bitstream words MSB-first onto one CCFF chain and captures the bits leaving its tail.
// Optional CRC-16-CCITT of the shifted stream: define CCFF_CHAIN_LOADER_CRC_EN.
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 36,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = 16
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic              abort,
    ccff_chain_loader_if.slave bs,
    output logic              ccff_head,
    output logic              config_enable,
    input  logic              ccff_tail,
    output logic [WORD_W-1:0] tail_word,
    output logic [CNT_W-1:0]  bit_count,
    output logic              busy,
    output logic              done
`ifdef CCFF_CHAIN_LOADER_CRC_EN
    ,
    output logic [15:0]       crc
`endif
);

    localparam int WB_W = $clog2(WORD_W) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t            state_q;
    logic [WORD_W-1:0] shreg_q;
    logic [WORD_W-1:0] tail_q;
    logic [WB_W-1:0]   word_bits_q;
    logic [CNT_W-1:0]  bit_count_q;

    logic [CNT_W-1:0]  bit_count_d;
    logic [WB_W-1:0]   word_bits_d;
    logic              last_bit;
    logic              last_word_bit;

    assign bit_count_d   = bit_count_q + CNT_W'(1);
    assign word_bits_d   = word_bits_q + WB_W'(1);
    assign last_bit      = (bit_count_d == CNT_W'(CHAIN_LEN));
    assign last_word_bit = (word_bits_d == WB_W'(WORD_W));

`ifdef CCFF_CHAIN_LOADER_CRC_EN
    logic [15:0] crc_q;

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        logic [15:0] n;
        n = {c[14:0], 1'b0};
        if (c[15] ^ b) n = n ^ 16'h1021;
        return n;
    endfunction

    assign crc = crc_q;
`endif

    // Every SHIFT cycle the chain samples ccff_head, so the bookkeeping for that
    // bit is committed even when abort arrives in the same cycle.
    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            state_q     <= S_IDLE;
            shreg_q     <= '0;
            tail_q      <= '0;
            word_bits_q <= '0;
            bit_count_q <= '0;
`ifdef CCFF_CHAIN_LOADER_CRC_EN
            crc_q       <= 16'hFFFF;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && !abort) begin
                        state_q     <= S_LOAD;
                        bit_count_q <= '0;
`ifdef CCFF_CHAIN_LOADER_CRC_EN
                        crc_q       <= 16'hFFFF;
`endif
                    end
                end
                S_LOAD: begin
                    if (abort) begin
                        state_q <= S_IDLE;
                    end else if (bs.in_valid) begin
                        shreg_q     <= bs.in_data;
                        word_bits_q <= '0;
                        state_q     <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    shreg_q     <= {shreg_q[WORD_W-2:0], 1'b0};
                    word_bits_q <= word_bits_d;
                    bit_count_q <= bit_count_d;
                    tail_q      <= {tail_q[WORD_W-2:0], ccff_tail};
`ifdef CCFF_CHAIN_LOADER_CRC_EN
                    crc_q       <= crc_step(crc_q, shreg_q[WORD_W-1]);
`endif
                    // Stopping at CHAIN_LEN drops whatever is left of the current word.
                    if (abort)              state_q <= S_IDLE;
                    else if (last_bit)      state_q <= S_DONE;
                    else if (last_word_bit) state_q <= S_LOAD;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign config_enable = (state_q == S_SHIFT);
    assign ccff_head     = config_enable & shreg_q[WORD_W-1];
    assign bs.in_ready   = (state_q == S_LOAD);
    assign busy          = (state_q == S_LOAD) || (state_q == S_SHIFT);
    assign done          = (state_q == S_DONE);
    assign tail_word     = tail_q;
    assign bit_count     = bit_count_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: table vectors, randomized loads against a stream model, and corner sequences.
module tb_ccff_chain_loader;
    localparam int CL = 36;
    localparam int W  = 8;
    localparam int CW = 16;
    localparam int NW = (CL + W - 1) / W;
    localparam int SW = 8 * NW;

    logic          prog_clk = 1'b0;
    logic          pReset, start, abort;
    logic          ccff_head, config_enable, ccff_tail, busy, done;
    logic [W-1:0]  tail_word;
    logic [CW-1:0] bit_count;
`ifdef CCFF_CHAIN_LOADER_CRC_EN
    logic [15:0]   crc36;
`endif

    ccff_chain_loader_if #(.WORD_W(W)) bus ();

    ccff_chain_loader #(.CHAIN_LEN(CL), .WORD_W(W), .CNT_W(CW)) dut (
        .prog_clk     (prog_clk),
        .pReset       (pReset),
        .start        (start),
        .abort        (abort),
        .bs           (bus),
        .ccff_head    (ccff_head),
        .config_enable(config_enable),
        .ccff_tail    (ccff_tail),
        .tail_word    (tail_word),
        .bit_count    (bit_count),
        .busy         (busy),
        .done         (done)
`ifdef CCFF_CHAIN_LOADER_CRC_EN
        ,
        .crc          (crc36)
`endif
    );

`ifdef CCFF_CHAIN_LOADER_CRC_EN
    logic          start8, ccff_head8, cfg_en8, busy8, done8;
    logic [W-1:0]  tail8;
    logic [CW-1:0] cnt8;
    logic [15:0]   crc8;
    ccff_chain_loader_if #(.WORD_W(W)) bus8 ();
    ccff_chain_loader #(.CHAIN_LEN(8), .WORD_W(W), .CNT_W(CW)) dut8 (
        .prog_clk(prog_clk), .pReset(pReset), .start(start8), .abort(1'b0), .bs(bus8),
        .ccff_head(ccff_head8), .config_enable(cfg_en8), .ccff_tail(1'b0),
        .tail_word(tail8), .bit_count(cnt8), .busy(busy8), .done(done8), .crc(crc8)
    );
`endif

    always #5 prog_clk = ~prog_clk;

    // Target chain: shifts toward the tail while config_enable is high; never reset.
    logic [CL-1:0] chain, preload_val;
    logic          preload_req = 1'b0;
    always @(posedge prog_clk) begin
        if (preload_req)        chain <= preload_val;
        else if (config_enable) chain <= {chain[CL-2:0], ccff_head};
    end
    assign ccff_tail = chain[CL-1];

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge prog_clk);
        #1;
    endtask

    task automatic preload(input logic [CL-1:0] p);
        preload_val = p;
        preload_req = 1'b1;
        tick();
        preload_req = 1'b0;
    endtask

    // Chain after k bits of the word stream entered a chain preloaded with pre.
    function automatic logic [CL-1:0] chain_f(input logic [CL-1:0] pre, input logic [SW-1:0] w, input int k);
        logic [CL+SW-1:0] x;
        x = {pre, w} >> (SW - k);
        return x[CL-1:0];
    endfunction

    // tail_word after k preload bits were expelled, newest in bit 0.
    function automatic logic [W-1:0] tail_f(input logic [W-1:0] old, input logic [CL-1:0] pre, input int k);
        logic [W+CL-1:0] x;
        x = {old, pre} >> (CL - k);
        return x[W-1:0];
    endfunction

    function automatic logic [15:0] crc_ref(input logic [7:0] b);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 7; i >= 0; i--) begin
            if (c[15] ^ b[i]) c = (c << 1) ^ 16'h1021;
            else              c = c << 1;
        end
        return c;
    endfunction

    logic [SW-1:0] ld_words;
    int            ld_stall[NW];
    int            ld_restart;
    int            ld_lat, ld_en, ld_done, ld_stall_bad;
    logic          ld_busy_after;

    task automatic do_load();
        int idx, scnt, cyc;
        logic rdy, acc;
        idx = 0; scnt = ld_stall[0]; cyc = 0;
        ld_lat = -1; ld_en = 0; ld_done = 0; ld_stall_bad = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        while (cyc < 400 && ld_lat < 0) begin
            bus.in_data  = (idx < NW) ? ld_words[SW-1-8*idx -: 8] : '0;
            bus.in_valid = (idx < NW) && (scnt == 0);
            start        = (cyc == ld_restart);
            rdy = bus.in_ready;
            acc = rdy & bus.in_valid;
            if (rdy && !bus.in_valid && (config_enable || ccff_head)) ld_stall_bad++;
            if (config_enable) ld_en++;
            tick();
            cyc++;
            if (acc) begin
                idx++;
                scnt = (idx < NW) ? ld_stall[idx] : 0;
            end else if (rdy && scnt > 0) begin
                scnt--;
            end
            if (done) begin
                ld_lat = cyc;
                ld_done++;
            end
        end
        bus.in_valid = 1'b0;
        start = 1'b1;   // lands in DONE and must be ignored
        tick();
        start = 1'b0;
        ld_busy_after = busy;
        for (int i = 0; i < 3; i++) begin
            if (done) ld_done++;
            tick();
        end
    endtask

    typedef struct packed {
        logic [39:0] words;
        logic [19:0] stalls;
        logic [35:0] pre;
        int          restart;
        logic [35:0] exp_chain;
        logic [7:0]  exp_tail;
        int          exp_lat;
    } vec_t;

    vec_t          vecs[5];
    logic [W-1:0]  model_tail;
    logic [63:0]   rw;
    logic [CL-1:0] rpre;
    int            ssum, en, idx, dc;
    logic          ab, rdy;

    initial begin
        vecs[0] = '{40'hA53CFF009F, 20'h00000, 36'h000000000, -1, 36'hA53CFF009, 8'h00, 42};
        vecs[1] = '{40'hA53CFF009F, 20'h000A0, 36'hF000000C3, -1, 36'hA53CFF009, 8'hC3, 52};
        vecs[2] = '{40'h123456789A, 20'h00000, 36'h012345678, -1, 36'h123456789, 8'h78, 42};
        vecs[3] = '{40'hFFFFFFFFF0, 20'h12301, 36'h800000001, 10, 36'hFFFFFFFFF, 8'h01, 49};
        vecs[4] = '{40'h0000000000, 20'h00000, 36'hFFFFFFFFF, 41, 36'h000000000, 8'hFF, 42};

        pReset = 1'b1; start = 1'b0; abort = 1'b0;
        bus.in_data = '0; bus.in_valid = 1'b0;
`ifdef CCFF_CHAIN_LOADER_CRC_EN
        start8 = 1'b0; bus8.in_data = '0; bus8.in_valid = 1'b0;
`endif
        tick(); tick();
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_head", ccff_head, 0);
        chk("rst_cfg_en", config_enable, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_bit_count", bit_count, 0);
        chk("rst_tail", tail_word, 0);
        pReset = 1'b0;
        tick();

        for (int r = 0; r < 5; r++) begin
            preload(vecs[r].pre);
            ld_words = vecs[r].words;
            for (int i = 0; i < NW; i++) ld_stall[i] = int'(vecs[r].stalls[19-4*i -: 4]);
            ld_restart = vecs[r].restart;
            do_load();
            chk($sformatf("vec%0d_latency", r), ld_lat, vecs[r].exp_lat);
            chk($sformatf("vec%0d_shift_cycles", r), ld_en, CL);
            chk($sformatf("vec%0d_done_pulses", r), ld_done, 1);
            chk($sformatf("vec%0d_chain", r), chain, vecs[r].exp_chain);
            chk($sformatf("vec%0d_tail_word", r), tail_word, vecs[r].exp_tail);
            chk($sformatf("vec%0d_bit_count", r), bit_count, CL);
            chk($sformatf("vec%0d_stall_quiet", r), ld_stall_bad, 0);
            chk($sformatf("vec%0d_start_in_done", r), ld_busy_after, 0);
            model_tail = vecs[r].exp_tail;
        end

        for (int r = 0; r < 12; r++) begin
            rw = {$urandom, $urandom};
            ld_words = rw[SW-1:0];
            rw = {$urandom, $urandom};
            rpre = rw[CL-1:0];
            ssum = 0;
            for (int i = 0; i < NW; i++) begin
                ld_stall[i] = int'($urandom_range(0, 3));
                ssum += ld_stall[i];
            end
            ld_restart = int'($urandom_range(2, 30));
            preload(rpre);
            do_load();
            model_tail = tail_f(model_tail, rpre, CL);
            chk($sformatf("rnd%0d_latency", r), ld_lat, 1 + NW + CL + ssum);
            chk($sformatf("rnd%0d_done_pulses", r), ld_done, 1);
            chk($sformatf("rnd%0d_chain", r), chain, chain_f(rpre, ld_words, CL));
            chk($sformatf("rnd%0d_tail_word", r), tail_word, model_tail);
            chk($sformatf("rnd%0d_bit_count", r), bit_count, CL);
        end

        // Abort raised together with the 13th shift cycle.
        rpre = 36'h012345678;
        preload(rpre);
        ld_words = 40'hA53CFF009F;
        en = 0; idx = 0; ab = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 100 && !ab; c++) begin
            bus.in_data  = ld_words[SW-1-8*idx -: 8];
            bus.in_valid = 1'b1;
            rdy = bus.in_ready;
            if (config_enable) begin
                en++;
                if (en == 13) begin
                    abort = 1'b1;
                    ab = 1'b1;
                end
            end
            tick();
            if (rdy) idx++;
        end
        abort = 1'b0;
        bus.in_valid = 1'b0;
        chk("abort_reached", ab, 1);
        chk("abort_busy", busy, 0);
        chk("abort_in_ready", bus.in_ready, 0);
        chk("abort_cfg_en", config_enable, 0);
        chk("abort_bit_count", bit_count, 13);
        chk("abort_chain", chain, chain_f(rpre, ld_words, 13));
        model_tail = tail_f(model_tail, rpre, 13);
        chk("abort_tail_word", tail_word, model_tail);
        dc = 0;
        for (int i = 0; i < 4; i++) begin
            if (done) dc++;
            tick();
        end
        chk("abort_no_done", dc, 0);
        chk("abort_count_held", bit_count, 13);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_bit_count", bit_count, 0);
        chk("restart_in_ready", bus.in_ready, 1);
        bus.in_data = 8'hFF; bus.in_valid = 1'b1; abort = 1'b1;
        tick();
        abort = 1'b0; bus.in_valid = 1'b0;
        chk("accept_abort_busy", busy, 0);
        chk("accept_abort_cfg_en", config_enable, 0);
        chk("accept_abort_count", bit_count, 0);
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("start_abort_idle", busy, 0);

        // Asynchronous reset in the middle of shifting.
        start = 1'b1;
        tick();
        start = 1'b0;
        bus.in_data = 8'hA5; bus.in_valid = 1'b1;
        for (int c = 0; c < 10 && !config_enable; c++) tick();
        tick(); tick(); tick();
        chk("pre_reset_shifting", config_enable, 1);
        #3 pReset = 1'b1;
        #1;
        chk("async_rst_busy", busy, 0);
        chk("async_rst_cfg_en", config_enable, 0);
        chk("async_rst_head", ccff_head, 0);
        chk("async_rst_in_ready", bus.in_ready, 0);
        chk("async_rst_done", done, 0);
        chk("async_rst_bit_count", bit_count, 0);
        chk("async_rst_tail", tail_word, 0);
        #1 pReset = 1'b0;
        bus.in_valid = 1'b0;
        tick();

`ifdef CCFF_CHAIN_LOADER_CRC_EN
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        bus8.in_data = 8'h31; bus8.in_valid = 1'b1;
        dc = 0;
        for (int c = 0; c < 30 && dc == 0; c++) begin
            tick();
            if (done8) dc++;
        end
        bus8.in_valid = 1'b0;
        chk("crc8_done", dc, 1);
        chk("crc8_value", crc8, crc_ref(8'h31));
        chk("crc8_bit_count", cnt8, 8);
`endif

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/ccff_chain_loader.md
Name: ccff_chain_loader

Overview:
- Sequences programming of one configuration-flip-flop (CCFF) chain, e.g. the 9×4-bit mux memory chain of a Y connection block.
- Accepts bitstream words over a valid/ready stream and serialises them onto ccff_head.
- Gates shifting with config_enable and stops after exactly CHAIN_LEN bits.
- Captures the bits leaving ccff_tail so the previous chain contents can be read back.
- Sits between the fabric-level bitstream distributor and each CCFF chain.

Parameters:
- CHAIN_LEN, 36: number of CCFF bits in the target chain (≥1).
- WORD_W, 8: bitstream word width (≥2).
- CNT_W, 16: width of the bit counter; CHAIN_LEN < 2**CNT_W.

Ports:
- prog_clk, input, 1: programming clock; all flops on its rising edge.
- pReset, input, 1: asynchronous, active-high reset.
- start, input, 1: pulse; begins a load when idle.
- abort, input, 1: terminates an in-progress load.
- in_data, input, WORD_W: bitstream word; MSB is shifted first.
- in_valid, input, 1: in_data valid.
- in_ready, output, 1: loader accepts a word this cycle.
- ccff_head, output, 1: serial data into the chain.
- config_enable, output, 1: chain shift enable.
- ccff_tail, input, 1: serial data out of the chain.
- tail_word, output, WORD_W: last WORD_W bits seen on ccff_tail; newest bit in bit 0.
- bit_count, output, CNT_W: bits shifted in the current or last load.
- busy, output, 1: high in LOAD or SHIFT.
- done, output, 1: one-cycle pulse when CHAIN_LEN bits have been shifted.

Behaviour:
- **Reset (async):**
  - State IDLE.
  - shreg, word_bits, bit_count and tail_word = 0.
  - Outputs: in_ready=0, ccff_head=0, config_enable=0, busy=0, done=0.
- **Outputs derived from registers only:**
  - config_enable = (state==SHIFT).
  - ccff_head = shreg[WORD_W-1] in SHIFT, else 0.
  - in_ready = (state==LOAD).
- **IDLE:**
  - start=1 → LOAD next cycle; bit_count cleared to 0 on the same edge.
  - abort in IDLE has no effect.
- **LOAD:**
  - in_valid & in_ready → shreg <= in_data, word_bits <= 0, go to SHIFT.
  - in_valid=0 → stay in LOAD (stall); config_enable stays 0, so the chain holds.
- **SHIFT, each cycle:**
  - Chain samples ccff_head.
  - shreg shifts left by 1 (zero fill).
  - word_bits += 1, bit_count += 1.
  - tail_word <= {tail_word[WORD_W-2:0], ccff_tail}.
- **Leaving SHIFT:**
  - bit_count+1 == CHAIN_LEN → DONE; any unshifted bits of the current word are discarded.
  - Else word_bits+1 == WORD_W → LOAD.
  - Else stay in SHIFT.
- **Per-word timing:**
  - One-cycle bubble (config_enable=0) between words.
  - Full word = 1 accept cycle + WORD_W shift cycles.
- **DONE:**
  - done=1 for exactly one cycle, then IDLE.
  - bit_count holds CHAIN_LEN until the next start.
- **Control interactions:**
  - start while busy or in DONE is ignored.
  - abort in LOAD or SHIFT → IDLE next cycle; config_enable drops immediately after the edge.
  - After abort: no done pulse; bit_count holds the partial count.
  - abort and start in the same cycle: abort wins; start is ignored.
  - An accept and abort in the same LOAD cycle: word is discarded.
- **Reset mid-load:** all state is lost; the chain is left partially shifted. Software must reload.

Optional Feature:
- Macro: CCFF_CHAIN_LOADER_CRC_EN.
- **When defined:**
  - Adds output crc, 16 bits.
  - CRC-16-CCITT (poly 0x1021, init 0xFFFF), updated with ccff_head on every SHIFT cycle.
  - Reset to 0xFFFF by pReset and on start acceptance.
  - Held after DONE or abort.
- **When undefined:** no crc port and no CRC logic.

Test Plan:
1. Reset values:
   - Stimulus: assert pReset mid-SHIFT.
   - Response: all outputs return to reset values asynchronously, before the next prog_clk edge.
2. Full load, CHAIN_LEN=36, WORD_W=8, words 0xA5,0x3C,0xFF,0x00,0x9F with in_valid always high:
   - config_enable high for exactly 36 cycles.
   - Serial stream is A5,3C,FF,00 followed by the upper nibble 0x9 (1001); low nibble 0xF discarded.
   - done pulses once; bit_count=36.
   - start to done = 42 cycles (1 + 5×1 accept + 36 shift).
3. Stall:
   - Stimulus: drop in_valid for 10 cycles before word 3.
   - Response: config_enable=0 and ccff_head=0 during the stall; final chain contents identical to test 2.
4. Readback:
   - Stimulus: model the chain as a 36-bit shift register preloaded with 36'h0_1234_5678; run a load.
   - Response: after done, tail_word equals the last 8 bits expelled per the model.
5. Abort:
   - Stimulus: assert abort after 13 shift cycles.
   - Response: IDLE next cycle, no done, bit_count=13, in_ready=0; a subsequent start restarts from bit_count=0.
6. CRC (CCFF_CHAIN_LOADER_CRC_EN defined):
   - Stimulus: CHAIN_LEN=8, single word 0x31 ("1").
   - Response: crc equals the reference CRC-16-CCITT (poly 0x1021, init 0xFFFF) of 0x31; without the macro, the port is absent.
